// File: rtl/bram_pkg.sv
// Shared definitions for the pipelined true dual-port BRAM.
//   clr_state_e      : clear-engine FSM states (IDLE, SWEEP)
//   RD_LAT_MIN/MAX   : legal READ_LATENCY range
//   num_lanes()      : NUM_LANES = DATA_WIDTH / BYTE_WIDTH
package bram_pkg;

  typedef enum logic {IDLE, SWEEP} clr_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int num_lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/bram_clear_fsm.sv
// Hardware clear engine: on CLEAR, sweeps every word address once so the top
// can force a zero write through port B.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : start request, ignored while a sweep is running
//   busy        : high for exactly 2**ADDR_WIDTH cycles while sweeping
//   clear_done  : one-cycle pulse in the first cycle after busy drops
//   clr_addr    : address to zero this cycle
module bram_clear_fsm
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  busy,
  output logic                  clear_done,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  clr_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      clear_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        cnt_nxt = cnt + ADDR_WIDTH'(1);
        // last address written this cycle: done lands with busy falling
        if (&cnt) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == SWEEP);
  assign clr_addr = cnt;

endmodule

// File: rtl/bram_tdp_pipelined.sv
// True dual-port block RAM with byte write enables, 1- or 2-cycle read latency
// with valid tracking, and registered cross-port collision detection.
// Optional macro BRAM_TDP_CLEAR_EN adds a clear engine that zeroes the array
// through port B and adds ports CLEAR / BUSY / CLEAR_DONE.
//   CLK, RST_N            : clock, asynchronous active-low reset
//   EN_x, RE_x, WE_x      : port enable, read request, byte write enables
//   ADDR_x, DI_x          : word address, write data
//   DO_x, DO_VALID_x      : read data (holds between reads), read valid
//   COLLISION             : pulse one cycle after same-address access with a writer
//   CLEAR, BUSY, CLEAR_DONE (macro only): start clear, sweeping, sweep finished
// Array contents are not touched by reset; PRELOADFILE names the boot image
// bound to the M20K blocks by the implementation flow, simulation starts with
// unknown contents.
module bram_tdp_pipelined
  import bram_pkg::*;
#(
  parameter int    DATA_WIDTH   = 32,
  parameter int    BYTE_WIDTH   = 8,
  parameter int    ADDR_WIDTH   = 9,
  parameter int    READ_LATENCY = 1,
  parameter string PRELOADFILE  = "blank_bram_512.txt"
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             EN_A,
  input  logic                             EN_B,
  input  logic                             RE_A,
  input  logic                             RE_B,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WE_A,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WE_B,
  input  logic [ADDR_WIDTH-1:0]            ADDR_A,
  input  logic [ADDR_WIDTH-1:0]            ADDR_B,
  input  logic [DATA_WIDTH-1:0]            DI_A,
  input  logic [DATA_WIDTH-1:0]            DI_B,
  output logic [DATA_WIDTH-1:0]            DO_A,
  output logic [DATA_WIDTH-1:0]            DO_B,
  output logic                             DO_VALID_A,
  output logic                             DO_VALID_B,
  output logic                             COLLISION
`ifdef BRAM_TDP_CLEAR_EN
  ,
  input  logic                             CLEAR,
  output logic                             BUSY,
  output logic                             CLEAR_DONE
`endif
);

  localparam int NUM_LANES = num_lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (PRELOADFILE == "") begin : g_bad_preload
    $error("PRELOADFILE must name the boot image");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // effective port controls, index 0 = A, 1 = B
  logic [1:0]                      en, re;
  logic [1:0][NUM_LANES-1:0]       we;
  logic [1:0][ADDR_WIDTH-1:0]      addr;
  logic [1:0][DATA_WIDTH-1:0]      di;
  wire  [1:0][DATA_WIDTH-1:0]      dout;
  wire  [1:0]                      dvld;

`ifdef BRAM_TDP_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_addr;

  bram_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear (
    .clk        (CLK),
    .rst_n      (RST_N),
    .clear      (CLEAR),
    .busy       (BUSY),
    .clear_done (CLEAR_DONE),
    .clr_addr   (clr_addr)
  );
`endif

  always_comb begin
    en   = {EN_B, EN_A};
    re   = {RE_B, RE_A};
    we   = {WE_B, WE_A};
    addr = {ADDR_B, ADDR_A};
    di   = {DI_B, DI_A};
`ifdef BRAM_TDP_CLEAR_EN
    // sweep owns port B and locks out port A; in-flight reads still drain
    if (BUSY) begin
      en      = 2'b10;
      re      = 2'b00;
      we[1]   = '1;
      addr[1] = clr_addr;
      di[1]   = '0;
    end
`endif
  end

  // B is applied first so A's later NBA wins on lanes both ports write
  always_ff @(posedge CLK) begin
    for (int p = 1; p >= 0; p--)
      for (int i = 0; i < NUM_LANES; i++)
        if (en[p] && we[p][i])
          mem[addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <= di[p][i*BYTE_WIDTH +: BYTE_WIDTH];
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_WIDTH-1:0]                    rd_word;
    logic [READ_LATENCY:1]                    vld_pipe;
    logic [READ_LATENCY:1][DATA_WIDTH-1:0]    dat_pipe;

    // write-first on the own port: merge this cycle's lanes into the read word
    always_comb begin
      rd_word = mem[addr[p]];
      for (int i = 0; i < NUM_LANES; i++)
        if (we[p][i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = di[p][i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        vld_pipe[1] <= en[p] && re[p];
        if (en[p] && re[p]) dat_pipe[1] <= rd_word;
        for (int s = 2; s <= READ_LATENCY; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
        end
      end
    end

    assign dout[p] = dat_pipe[READ_LATENCY];
    assign dvld[p] = vld_pipe[READ_LATENCY];
  end

  assign DO_A       = dout[0];
  assign DO_B       = dout[1];
  assign DO_VALID_A = dvld[0];
  assign DO_VALID_B = dvld[1];

  logic [1:0] wr, acc;
  logic       coll_d;

  assign wr     = {en[1] && (|we[1]), en[0] && (|we[0])};
  assign acc    = en & (re | wr);
  assign coll_d = (&acc) && (|wr) && (addr[0] == addr[1]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) COLLISION <= 1'b0;
    else        COLLISION <= coll_d;
  end

endmodule

// File: tb/tb_bram_tdp_pipelined.sv
// Directed bench for bram_tdp_pipelined: one latency-1 and one latency-2
// instance share all inputs, so each scenario is checked at both latencies.
// Clear-engine scenarios are built only with BRAM_TDP_CLEAR_EN.
module tb_bram_tdp_pipelined;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          EN_A, EN_B, RE_A, RE_B;
  logic [3:0]    WE_A, WE_B, ADDR_A, ADDR_B;
  logic [DW-1:0] DI_A, DI_B;
  logic [DW-1:0] do_a1, do_b1, do_a2, do_b2;
  logic          dv_a1, dv_b1, dv_a2, dv_b2, coll1, coll2;
`ifdef BRAM_TDP_CLEAR_EN
  logic          CLEAR = 1'b0;
  logic          busy1, busy2, done1, done2;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  bram_tdp_pipelined #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
                       .READ_LATENCY(1), .PRELOADFILE("blank_bram_512.txt")) u_l1 (
    .CLK(CLK), .RST_N(RST_N), .EN_A(EN_A), .EN_B(EN_B), .RE_A(RE_A), .RE_B(RE_B),
    .WE_A(WE_A), .WE_B(WE_B), .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .DI_A(DI_A), .DI_B(DI_B),
    .DO_A(do_a1), .DO_B(do_b1), .DO_VALID_A(dv_a1), .DO_VALID_B(dv_b1), .COLLISION(coll1)
`ifdef BRAM_TDP_CLEAR_EN
    , .CLEAR(CLEAR), .BUSY(busy1), .CLEAR_DONE(done1)
`endif
  );

  bram_tdp_pipelined #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
                       .READ_LATENCY(2), .PRELOADFILE("blank_bram_512.txt")) u_l2 (
    .CLK(CLK), .RST_N(RST_N), .EN_A(EN_A), .EN_B(EN_B), .RE_A(RE_A), .RE_B(RE_B),
    .WE_A(WE_A), .WE_B(WE_B), .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .DI_A(DI_A), .DI_B(DI_B),
    .DO_A(do_a2), .DO_B(do_b2), .DO_VALID_A(dv_a2), .DO_VALID_B(dv_b2), .COLLISION(coll2)
`ifdef BRAM_TDP_CLEAR_EN
    , .CLEAR(CLEAR), .BUSY(busy2), .CLEAR_DONE(done2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    EN_A = 1'b0; RE_A = 1'b0; WE_A = 4'h0; ADDR_A = 4'h0; DI_A = 32'h0;
    EN_B = 1'b0; RE_B = 1'b0; WE_B = 4'h0; ADDR_B = 4'h0; DI_B = 32'h0;
  endtask

  task automatic port_a(input logic re, input logic [3:0] we, input logic [3:0] a, input logic [31:0] d);
    EN_A = 1'b1; RE_A = re; WE_A = we; ADDR_A = a; DI_A = d;
  endtask

  task automatic port_b(input logic re, input logic [3:0] we, input logic [3:0] a, input logic [31:0] d);
    EN_B = 1'b1; RE_B = re; WE_B = we; ADDR_B = a; DI_B = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

  initial begin
`ifdef BRAM_TDP_CLEAR_EN
    int busy_n, busy_n2, done_n, vld_n;
    logic done_ok;
`endif
    idle();

    // reset state
    #12;
    chk("rst do l1", do_a1 | do_b1, 32'h0);
    chk("rst do l2", do_a2 | do_b2, 32'h0);
    chk("rst flags", 32'({dv_a1, dv_b1, coll1, dv_a2, dv_b2, coll2}), 32'h0);
    RST_N = 1'b1;
    step();

    // byte-lane write, read from the other port next cycle
    port_a(1'b0, 4'hF, 4'd3, 32'h11223344); step();
    port_a(1'b0, 4'b0101, 4'd3, 32'hAABBCCDD); step();
    idle(); port_b(1'b1, 4'h0, 4'd3, 32'h0); step();
    chk("bytewr do_b l1", do_b1, 32'h11BB33DD);
    chk("bytewr vld_b l1", 32'(dv_b1), 32'd1);
    chk("bytewr vld_b l2 early", 32'(dv_b2), 32'd0);
    idle(); step();
    chk("bytewr do_b l2", do_b2, 32'h11BB33DD);
    chk("bytewr vld_b l2", 32'(dv_b2), 32'd1);
    chk("bytewr vld_b l1 drop", 32'(dv_b1), 32'd0);
    chk("bytewr do_b l1 hold", do_b1, 32'h11BB33DD);

    // back-to-back reads of 0,1,2
    for (int k = 0; k < 3; k++) begin
      idle(); port_a(1'b0, 4'hF, 4'(k), 32'hA0 + k); step();
    end
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k < 3) port_a(1'b1, 4'h0, 4'(k), 32'h0);
      step();
      chk($sformatf("lat%0d l1 vld", k), 32'(dv_a1), (k < 3) ? 1 : 0);
      chk($sformatf("lat%0d l1 do", k), do_a1, 32'hA0 + ((k < 3) ? k : 2));
      chk($sformatf("lat%0d l2 vld", k), 32'(dv_a2), (k >= 1 && k <= 3) ? 1 : 0);
      if (k >= 1) chk($sformatf("lat%0d l2 do", k), do_a2, 32'hA0 + ((k - 1 < 2) ? k - 1 : 2));
    end

    // write-write collision, full word
    idle(); port_a(1'b0, 4'hF, 4'd5, 32'h1); port_b(1'b0, 4'hF, 4'd5, 32'h2); step();
    chk("ww coll l1", 32'(coll1), 32'd1);
    chk("ww coll l2", 32'(coll2), 32'd1);
    idle(); step();
    chk("ww coll pulse", 32'({coll1, coll2}), 32'h0);
    port_a(1'b1, 4'h0, 4'd5, 32'h0); step();
    chk("ww mem l1", do_a1, 32'h1);
    idle(); step();
    chk("ww mem l2", do_a2, 32'h1);

    // write-write collision, partial lane overlap
    port_a(1'b0, 4'hF, 4'd6, 32'h0); step();
    idle(); port_a(1'b0, 4'b0011, 4'd6, 32'hAAAAAAAA); port_b(1'b0, 4'b0110, 4'd6, 32'hBBBBBBBB); step();
    idle(); port_b(1'b1, 4'h0, 4'd6, 32'h0); step();
    chk("lane mix", do_b1, 32'h00BBAAAA);

    // same-port read during write
    idle(); port_a(1'b1, 4'hF, 4'd7, 32'h55); step();
    chk("rdw do l1", do_a1, 32'h55);
    chk("rdw coll", 32'({coll1, coll2}), 32'h0);
    idle(); step();
    chk("rdw do l2", do_a2, 32'h55);

    // cross-port read vs write, disjoint writes, read-read
    port_a(1'b1, 4'h0, 4'd8, 32'h0); port_b(1'b0, 4'hF, 4'd8, 32'h77); step();
    chk("rw coll", 32'(coll1), 32'd1);
    chk("rw vld", 32'(dv_a1), 32'd1);
    idle(); port_a(1'b0, 4'hF, 4'd9, 32'h1); port_b(1'b0, 4'hF, 4'd10, 32'h2); step();
    chk("diff addr no coll", 32'(coll1), 32'd0);
    idle(); port_a(1'b1, 4'h0, 4'd5, 32'h0); port_b(1'b1, 4'h0, 4'd5, 32'h0); step();
    chk("rr no coll", 32'(coll1), 32'd0);

    // async reset while a latency-2 read and a collision are in flight
    idle(); port_a(1'b1, 4'h0, 4'd7, 32'h0); port_b(1'b0, 4'hF, 4'd7, 32'h55); step();
    chk("mrst pre coll", 32'(coll2), 32'd1);
    chk("mrst pre do l2", do_a2, 32'h1);
    idle(); #2; RST_N = 1'b0; #1;
    chk("mrst do l1", do_a1, 32'h0);
    chk("mrst do l2", do_a2, 32'h0);
    chk("mrst flags", 32'({dv_a1, dv_a2, dv_b1, dv_b2, coll1, coll2}), 32'h0);
    step(); RST_N = 1'b1; step();
    chk("mrst read lost", 32'(dv_a2), 32'd0);
    port_a(1'b1, 4'h0, 4'd7, 32'h0); step();
    chk("mrst mem kept l1", do_a1, 32'h55);
    idle(); step();
    chk("mrst mem kept l2", do_a2, 32'h55);

`ifdef BRAM_TDP_CLEAR_EN
    // full clear with user traffic during the sweep
    for (int a = 0; a < 16; a++) begin
      idle(); port_a(1'b0, 4'hF, 4'(a), 32'hFF); step();
    end
    idle(); CLEAR = 1'b1; step(); CLEAR = 1'b0;
    busy_n = 0; busy_n2 = 0; done_n = 0; vld_n = 0; done_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      busy_n  += int'(busy1);
      busy_n2 += int'(busy2);
      if (done1) begin
        done_n++;
        if (busy1) done_ok = 1'b0;
      end
      vld_n += int'(dv_a1) + int'(dv_a2) + int'(dv_b1) + int'(dv_b2);
      idle();
      CLEAR = (k == 5);
      if (busy1) begin
        port_a(1'b1, 4'hF, 4'(k), 32'h1234);
        port_b(1'b1, 4'hF, 4'(15 - k), 32'h5678);
      end
      step();
    end
    CLEAR = 1'b0;
    chk("clr busy cycles l1", busy_n, 32'd16);
    chk("clr busy cycles l2", busy_n2, 32'd16);
    chk("clr done count", done_n, 32'd1);
    chk("clr done with busy low", 32'(done_ok), 32'd1);
    chk("clr no user valid", vld_n, 32'd0);
    for (int a = 0; a < 17; a++) begin
      idle();
      if (a < 16) port_a(1'b1, 4'h0, 4'(a), 32'h0);
      step();
      if (a < 16) chk($sformatf("clr rd%0d l1", a), do_a1, 32'h0);
      if (a > 0) chk($sformatf("clr rd%0d l2", a - 1), do_a2, 32'h0);
    end

    // reset part-way through a sweep
    for (int a = 0; a < 16; a++) begin
      idle(); port_a(1'b0, 4'hF, 4'(a), 32'hFF); step();
    end
    idle(); CLEAR = 1'b1; step(); CLEAR = 1'b0;
    repeat (6) step();
    chk("swrst pre busy", 32'({busy1, busy2}), 32'h3);
    #2; RST_N = 1'b0; #1;
    chk("swrst busy", 32'({busy1, busy2}), 32'h0);
    chk("swrst done", 32'({done1, done2}), 32'h0);
    step(); RST_N = 1'b1; step();
    chk("swrst stays idle", 32'({busy1, done1}), 32'h0);
    for (int a = 0; a < 16; a++) begin
      idle(); port_a(1'b1, 4'h0, 4'(a), 32'h0); step();
      chk($sformatf("swrst rd%0d", a), do_a1, (a < 6) ? 32'h0 : 32'hFF);
    end
`endif

    idle(); step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
